// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: word type, fetch FSM encoding and address helpers.
`default_nettype none

package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t INSN_BYTES = 32'd4;

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// Instruction-cache request port between the fetch stage (master) and the icache (slave).
`default_nettype none

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;

  modport master (
    input  ihit,
    input  imemload,
    output imemREN,
    output imemaddr
  );

  modport slave (
    output ihit,
    output imemload,
    input  imemREN,
    input  imemaddr
  );

endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instructions from the icache and feeds IF/ID.
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master icache,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  word_t        redirect_pc_i,
  input  logic         halt_i,
  output word_t        ifid_npc,
  output word_t        ifid_iload,
  output logic         ifid_en,
  output logic         ifid_flush,
  output logic         halted
);

  fetch_state_t state;
  word_t        pc;
  word_t        hold_addr;
  logic         halt_pend;

  word_t pc_plus4;
  word_t redirect_target;
  logic  halt_pend_next;

  assign pc_plus4        = pc + INSN_BYTES;
  assign redirect_target = word_align(redirect_pc_i);
  assign ifid_npc        = pc_plus4;
  assign ifid_iload      = icache.imemload;

  // A redirect during a squash discards any halt seen on the abandoned path.
  assign halt_pend_next = !redirect_i && (halt_pend || halt_i);

  always_comb begin
    icache.imemREN  = 1'b0;
    icache.imemaddr = pc;
    ifid_en         = 1'b0;
    ifid_flush      = 1'b0;
    halted          = 1'b0;
    if (!RST) begin
      case (state)
        FETCH: begin
          icache.imemREN = 1'b1;
          if (redirect_i || halt_i) begin
            ifid_flush = 1'b1;
          end else if (icache.ihit && !stall_i) begin
            ifid_en = 1'b1;
          end
        end
        SQUASH: begin
          icache.imemREN  = 1'b1;
          icache.imemaddr = hold_addr;
          ifid_flush      = redirect_i;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          icache.imemREN = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hold_addr <= RESET_PC;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_i) begin
            pc <= redirect_target;
            if (!icache.ihit) begin
              hold_addr <= pc;
              halt_pend <= 1'b0;
              state     <= SQUASH;
            end
          end else if (halt_i) begin
            if (icache.ihit) begin
              state <= HALTED;
            end else begin
              hold_addr <= pc;
              halt_pend <= 1'b1;
              state     <= SQUASH;
            end
          end else if (icache.ihit && !stall_i) begin
            pc <= pc_plus4;
          end
        end
        SQUASH: begin
          if (redirect_i) begin
            pc <= redirect_target;
          end
          halt_pend <= halt_pend_next;
          if (icache.ihit) begin
            state <= halt_pend_next ? HALTED : FETCH;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  a_squash_addr_stable : assert property (@(posedge CLK) disable iff (RST)
    (state == SQUASH && !icache.ihit) |=> (icache.imemaddr == $past(icache.imemaddr)));

  a_en_flush_exclusive : assert property (@(posedge CLK) disable iff (RST)
    !(ifid_en && ifid_flush));

endmodule

`default_nettype wire
